fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequences the synchronous instruction memory: owns the program counter and drives the memory's word-aligned byte address.
- Tracks the fixed 1-cycle read latency and discards responses made stale by a redirect.
- Buffers fetched {pc, instruction} pairs in a small FIFO and hands them to decode with a valid/ready handshake.
- Sits between the instruction memory and the decode stage; branch/jump redirects come from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, output buffer entries (>=2); sized to sustain 1 instr/cycle.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- fetch_en  input  1  level; 1 = fetching permitted.
- imem_addr  output  32  byte address to instruction memory; equals pc_q (register output, no combinational path).
- imem_rdata  input  32  instruction memory read data; valid one cycle after address.
- redirect_valid  input  1  single-cycle pulse; load new PC and flush.
- redirect_pc  input  32  redirect target byte address.
- out_valid  output  1  FIFO head valid (registered).
- out_ready  input  1  decode accepts head this cycle.
- out_instr  output  32  FIFO head instruction.
- out_pc  output  32  FIFO head PC.
- misalign_err  output  1  sticky misaligned-redirect flag; see Optional Feature.

Behaviour:
- Reset (async, immediate):
  - pc_q=RESET_PC; state=IDLE; inflight_q=0; FIFO count=0.
  - out_valid=0; out_instr=0; out_pc=0; misalign_err=0.
- States:
  - IDLE: no issue. If fetch_en=1, go to RUN.
  - RUN: issue permitted. If fetch_en=0, go to IDLE; an in-flight read still completes and is pushed.
  - HALT: entered only by the misalign trap. No issue; exit only via rst.
- Issue condition: state==RUN AND (count + inflight_q - pop) < FIFO_DEPTH, where pop = out_valid && out_ready.
- On issue:
  - pc_q <= pc_q + 4, wrapping modulo 2^32.
  - inflight_q <= 1, and inflight_pc_q <= pc_q.
- Without issue: inflight_q <= 0 and pc_q holds. The memory still reads every cycle; that data is ignored.
- Push: when inflight_q=1 and no redirect this cycle, write {inflight_pc_q, imem_rdata} to the FIFO tail.
- Simultaneous push and pop: allowed; count unchanged.
- Pop: head advances when out_valid && out_ready. Head fields are stable while out_valid=1 && out_ready=0.
- The FIFO never overflows, by construction of the issue condition. Pop on empty is impossible because out_valid=0.
- Redirect (highest priority, same edge):
  - pc_q <= {redirect_pc[31:2], 2'b00}.
  - FIFO count <= 0 and out_valid <= 0.
  - inflight_q <= 0; no issue this cycle.
  - The imem_rdata present this cycle is dropped.
  - Any pop in the same cycle is still honoured: decode took the head, then the FIFO is flushed.
- Redirect in IDLE: PC is updated; nothing is fetched until RUN.
- Latency:
  - Redirect in cycle N (in RUN): imem_addr=target in N+1; first out_valid with out_pc=target in N+3.
  - From reset: fetch_en=1 in cycle 0 → address RESET_PC in cycle 1 → out_valid in cycle 3.
- Throughput: 1 instr/cycle with out_ready held high.
- The memory returns NOP (0x13) while in reset. This value is never pushed, because inflight_q=0 out of reset.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err=1 (sticky until rst).
  - State goes to HALT; FIFO is flushed and inflight_q is cleared.
  - pc_q loads the unaligned redirect_pc unmodified, for debug visibility.
- Undefined:
  - misalign_err is tied 0.
  - Low bits are silently forced to 00 and fetching continues.

Test Plan:
- Reset release, fetch_en=1, out_ready=1, mem[0..3]=A0..A3:
  - out_valid first in cycle 3.
  - Then out_pc=0,4,8,12 with instr A0..A3 on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles mid-stream:
  - count saturates at 2 and imem_addr stops advancing.
  - After release, no instruction is lost or duplicated and out_pc is strictly +4.
- Redirect to 0x40 while FIFO full and inflight=1:
  - Next cycle out_valid=0.
  - out_pc=0x40 appears in cycle N+3; no stale PC is ever presented.
- Redirect and pop in the same cycle: the popped head is consumed once, then the flush applies, and the next out_pc=target.
- PC wrap: RESET_PC=32'hFFFF_FFFC → out_pc sequence FFFF_FFFC, 0000_0000.
- Misalign redirect to 0x42:
  - With macro: misalign_err=1, state HALT, out_valid stays 0; rst clears all.
  - Without macro: fetch resumes at 0x40.

Source files
------------

// File: rtl/fetch_controller.sv
// ----------------------------------------------------------------------------
// fetch_controller
//
// Owns the program counter and sequences a synchronous instruction memory
// with a fixed 1-cycle read latency. Returned words are paired with the PC
// they were fetched from and buffered in a small FIFO that feeds decode.
// Redirects from execute reload the PC and discard everything in flight.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a non-word-aligned target sets the sticky
//               misalign_err flag and parks the FSM in HALT until rst.
//   undefined : misalign_err is tied 0 and the target's low bits are cleared.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   fetch_en         level; 1 = fetching permitted
//   imem_addr        byte address to instruction memory (= pc_q)
//   imem_rdata       memory read data, valid one cycle after imem_addr
//   redirect_valid   single-cycle pulse: load redirect_pc and flush
//   redirect_pc      redirect target byte address
//   out_valid        FIFO head valid
//   out_ready        decode accepts the head this cycle
//   out_instr        FIFO head instruction
//   out_pc           FIFO head PC
//   misalign_err     sticky misaligned-redirect flag
//   state_dbg        FSM state (0 = IDLE, 1 = RUN, 2 = HALT)
//
// Handshake: a head entry transfers on a rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 the head fields are
// held stable. out_valid never depends combinationally on out_ready.
// ----------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign_err,
    output logic [1:0]  state_dbg
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          state_q;
    logic [31:0]     pc_q;
    logic [31:0]     inflight_pc_q;
    logic            inflight_q;
    logic [CW-1:0]   count_q;
    logic            valid_q;
    logic [31:0]     fifo_pc    [FIFO_DEPTH];
    logic [31:0]     fifo_instr [FIFO_DEPTH];

    logic            pop;
    logic            push;
    logic            issue;
    logic            trap;
    logic [OW-1:0]   occupancy;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   write_idx;
    logic [31:0]     redirect_target;

    assign pop  = valid_q && out_ready;
    assign push = inflight_q && !redirect_valid;

    // Entries held or already promised (in flight) after this cycle's pop;
    // issuing only below depth guarantees the FIFO can never overflow.
    assign occupancy = {1'b0, count_q} + OW'(inflight_q) - OW'(pop);
    assign issue     = (state_q == S_RUN) && !redirect_valid && (occupancy < OW'(FIFO_DEPTH));

    // With a simultaneous pop the entries shift down first, so the tail slot
    // is one lower. pop implies count_q >= 1, so this cannot underflow.
    assign write_idx = count_q - CW'(pop);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;
    assign trap         = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign misalign_err = misalign_q;
    // The unaligned target is kept as-is so it is visible on imem_addr.
    assign redirect_target = trap ? redirect_pc : {redirect_pc[31:2], 2'b00};
`else
    assign trap            = 1'b0;
    assign misalign_err    = 1'b0;
    assign redirect_target = {redirect_pc[31:2], 2'b00};
`endif

    always_comb begin
        count_d = count_q;
        if (redirect_valid) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            valid_q       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE:  if (fetch_en)  state_q <= S_RUN;
                S_RUN:   if (!fetch_en) state_q <= S_IDLE;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
            if (trap) begin
                state_q <= S_HALT;
            end

            count_q <= count_d;
            valid_q <= (count_d != '0);

            if (redirect_valid) begin
                // Any in-flight response and this cycle's rdata are dropped.
                pc_q       <= redirect_target;
                inflight_q <= 1'b0;
            end else begin
                if (issue) begin
                    pc_q          <= pc_q + 32'd4;
                    inflight_q    <= 1'b1;
                    inflight_pc_q <= pc_q;
                end else begin
                    inflight_q    <= 1'b0;
                end
                if (pop) begin
                    for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                        fifo_pc[i]    <= fifo_pc[i + 1];
                        fifo_instr[i] <= fifo_instr[i + 1];
                    end
                end
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (push && (write_idx == CW'(i))) begin
                        fifo_pc[i]    <= inflight_pc_q;
                        fifo_instr[i] <= imem_rdata;
                    end
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (trap) begin
            misalign_q <= 1'b1;
        end
    end
`endif

    assign imem_addr = pc_q;
    assign out_valid = valid_q;
    assign out_pc    = fifo_pc[0];
    assign out_instr = fifo_instr[0];
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// ----------------------------------------------------------------------------
// Bench for fetch_controller. The reference model sees the fetch stream as
// "consecutive word addresses from the last start point": after reset the
// stream starts at RESET_PC, after each redirect at the aligned target. Every
// presented head must match the front of that stream, and memory contents are
// a fixed function of the address, so the instruction is checkable too.
// A second instance with RESET_PC = FFFF_FFFC covers PC wrap out of reset.
// ----------------------------------------------------------------------------
module tb_fetch_controller;

    localparam logic [31:0] RPC = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;
    logic [1:0]  state_dbg;

    logic [31:0] w_addr, w_rdata, w_instr, w_pc;
    logic        w_valid, w_err;
    logic [1:0]  w_state;

    fetch_controller #(.RESET_PC(RPC), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .misalign_err(misalign_err), .state_dbg(state_dbg)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_wrap (
        .clk(clk), .rst(rst), .fetch_en(1'b1),
        .imem_addr(w_addr), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(w_valid), .out_ready(1'b1),
        .out_instr(w_instr), .out_pc(w_pc),
        .misalign_err(w_err), .state_dbg(w_state)
    );

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_rdata <= 32'h0000_0013;
            w_rdata    <= 32'h0000_0013;
        end else begin
            imem_rdata <= mem_word(imem_addr);
            w_rdata    <= mem_word(w_addr);
        end
    end

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp_tail;
    bit          halted;
    bit          mis;

    task automatic restart_stream(input logic [31:0] start);
        exp_q.delete();
        exp_tail = start;
        exp_q.push_back(start);
        while (exp_q.size() < 4) begin
            exp_tail = exp_tail + 32'd4;
            exp_q.push_back(exp_tail);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            halted = 1'b0;
            restart_stream(RPC);
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got out_pc %h, expected no output", out_pc);
                end else begin
                    check("sb_pc", out_pc, exp_q[0]);
                    check("sb_instr", out_instr, mem_word(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        exp_tail = exp_tail + 32'd4;
                        exp_q.push_back(exp_tail);
                    end
                end
            end
            // A pop in the redirect cycle was consumed above; now flush.
            if (redirect_valid) begin
                mis = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                mis = (redirect_pc[1:0] != 2'b00);
`endif
                if (mis) halted = 1'b1;
                if (halted) exp_q.delete();
                else restart_stream({redirect_pc[31:2], 2'b00});
            end
        end
    end

    // Wrap instance: first outputs must be FFFF_FFFC, 0000_0000, 0000_0004.
    int          w_seen;
    logic [31:0] w_exp [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    always @(negedge clk) begin
        if (rst) begin
            w_seen = 0;
        end else if (w_valid && w_seen < 3) begin
            check("wrap_pc", w_pc, w_exp[w_seen]);
            check("wrap_instr", w_instr, mem_word(w_exp[w_seen]));
            w_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Redirect in cycle N; expect imem_addr=target in N+1, head at N+3.
    task automatic do_redirect(input logic [31:0] target, input logic [31:0] exp_addr);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = target;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_addr_n1", imem_addr, exp_addr);
        check("redir_valid_n1", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("redir_valid_n2", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("redir_valid_n3", {31'b0, out_valid}, 32'd1);
        check("redir_pc_n3", out_pc, exp_addr);
    endtask

    task automatic reset_checks();
        @(negedge clk);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_addr", imem_addr, RPC);
        check("rst_err", {31'b0, misalign_err}, 32'd0);
        check("rst_state", {30'b0, state_dbg}, 32'd0);
    endtask

    // ---------------- main stimulus ----------------
    logic [31:0] prev_addr;

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        reset_checks();
        next_cycle();
        rst = 1'b0;

        // Reset-release latency and full-rate streaming.
        next_cycle();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("lat_valid", {31'b0, out_valid}, (k >= 3) ? 32'd1 : 32'd0);
            if (k == 1) check("lat_addr", imem_addr, RPC);
            if (k >= 3) check("lat_pc", out_pc, RPC + 32'((k - 3) * 4));
        end

        // Backpressure: address must freeze once the buffer is committed.
        next_cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            if (i >= 2) check("bp_addr_hold", imem_addr, prev_addr);
            prev_addr = imem_addr;
        end
        next_cycle();
        out_ready = 1'b1;

        // Redirect coinciding with a pop, fifo holding one + one in flight.
        do_redirect(32'h0000_0040, 32'h0000_0040);
        repeat (4) next_cycle();

        // Redirect with the buffer full and decode stalled.
        out_ready = 1'b0;
        repeat (4) next_cycle();
        do_redirect(32'h0000_0080, 32'h0000_0080);
        out_ready = 1'b1;
        repeat (3) next_cycle();

        // Wrap through the top of the address space.
        do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
        repeat (5) next_cycle();

        // Misaligned redirect.
`ifdef FETCH_MISALIGN_TRAP_EN
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("mis_err", {31'b0, misalign_err}, 32'd1);
        check("mis_state", {30'b0, state_dbg}, 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mis_valid", {31'b0, out_valid}, 32'd0);
            check("mis_addr", imem_addr, 32'h0000_0042);
        end
        next_cycle();
        rst = 1'b1;
        reset_checks();
        next_cycle();
        rst = 1'b0;
`else
        do_redirect(32'h0000_0042, 32'h0000_0040);
        check("mis_err_off", {31'b0, misalign_err}, 32'd0);
`endif
        repeat (4) next_cycle();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            fetch_en       = ($urandom_range(0, 15) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
            else redirect_pc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            redirect_pc[1:0] = 2'b00;
`endif
        end
        next_cycle();
        redirect_valid = 1'b0;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        repeat (10) next_cycle();

        if (w_seen != 3) begin
            tests++;
            fails++;
            $display("FAIL wrap_count: got %0d outputs expected 3", w_seen);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
